// File: rtl/fix_checksum_ctrl.sv
// fix_checksum_ctrl
//   Frames FIX messages from "8=" to "10=ddd<SOH>", drives the shared checksum
//   accumulator, converts the received ASCII checksum to binary and reports
//   one verdict per message.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-low reset
//   data_i, valid_i incoming byte stream, no backpressure
//   acc_clr_o/acc_en_o/acc_data_o  combinational accumulator strobes
//   sum_i           current accumulator value
//   busy_o          a message is in progress
//   done_o, ok_o, err_o, csum_o    registered verdict (err: 0 none, 1 header,
//                   2 trailer format, 3 mismatch, 4 overlength)
module fix_checksum_ctrl #(
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       acc_clr_o,
  output logic       acc_en_o,
  output logic [7:0] acc_data_o,
  input  logic [7:0] sum_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       ok_o,
  output logic [2:0] err_o,
  output logic [7:0] csum_o
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam logic [7:0] SOH = 8'h01;

  typedef enum logic [3:0] {
    IDLE, HDR_EQ, BODY, T1, T0, TEQ, D0, D1, D2, TERM
  } state_t;

  state_t        state;
  logic [7:0]    pend;
  logic [9:0]    val;
  logic [CW-1:0] len_cnt;

  logic          overlen;
  logic [7:0]    tag_byte;
  logic          is_digit;
  logic [9:0]    val_next;
  logic          fin;
  logic          fin_ok;
  logic [2:0]    fin_err;

  // Current byte would be number MAX_LEN+1 of the message.
  assign overlen  = (len_cnt == CW'(MAX_LEN));
  assign is_digit = (data_i >= 8'h30) && (data_i <= 8'h39);
  // For ASCII '0'..'9' the low nibble is the digit value.
  assign val_next = (val * 10'd10) + {6'b0, data_i[3:0]};
  assign busy_o   = (state != IDLE);

  always_comb begin
    tag_byte = '0;
    case (state)
      T1:      tag_byte = 8'h31;
      T0:      tag_byte = 8'h30;
      TEQ:     tag_byte = 8'h3D;
      default: tag_byte = '0;
    endcase
  end

  // Accumulator strobes; trailer-tag bytes are held in pend until they are
  // known not to be the real "10=" tag, then flushed as one combined add.
  always_comb begin
    acc_clr_o  = 1'b0;
    acc_en_o   = 1'b0;
    acc_data_o = '0;
    if (valid_i) begin
      case (state)
        IDLE: if (data_i == 8'h38) begin
          acc_clr_o  = 1'b1;
          acc_en_o   = 1'b1;
          acc_data_o = data_i;
        end
        HDR_EQ: if (!overlen && data_i == 8'h3D) begin
          acc_en_o   = 1'b1;
          acc_data_o = data_i;
        end
        BODY: if (!overlen) begin
          acc_en_o   = 1'b1;
          acc_data_o = data_i;
        end
        T1, T0, TEQ: if (!overlen && data_i != tag_byte) begin
          acc_en_o   = 1'b1;
          acc_data_o = pend + data_i;
        end
        default: ;
      endcase
    end
  end

  // Message-terminating conditions and their verdict.
  always_comb begin
    fin     = 1'b0;
    fin_ok  = 1'b0;
    fin_err = 3'd0;
    if (valid_i && state != IDLE) begin
      if (overlen) begin
        fin     = 1'b1;
        fin_err = 3'd4;
      end else begin
        case (state)
          HDR_EQ: if (data_i != 8'h3D) begin
            fin     = 1'b1;
            fin_err = 3'd1;
          end
          D0, D1, D2: if (!is_digit) begin
            fin     = 1'b1;
            fin_err = 3'd2;
          end
          TERM: begin
            fin = 1'b1;
            if (data_i == SOH) begin
              fin_ok  = (val == {2'b0, sum_i});
              fin_err = (val == {2'b0, sum_i}) ? 3'd0 : 3'd3;
            end else begin
              fin_err = 3'd2;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      pend    <= '0;
      val     <= '0;
      len_cnt <= '0;
      done_o  <= 1'b0;
      ok_o    <= 1'b0;
      err_o   <= '0;
      csum_o  <= '0;
    end else begin
      done_o <= 1'b0;
      if (valid_i) begin
        if (fin) begin
          done_o <= 1'b1;
          ok_o   <= fin_ok;
          err_o  <= fin_err;
          csum_o <= sum_i;
          state  <= IDLE;
          pend   <= '0;
          val    <= '0;
        end else begin
          if (state != IDLE) len_cnt <= len_cnt + CW'(1);
          case (state)
            IDLE: if (data_i == 8'h38) begin
              state   <= HDR_EQ;
              len_cnt <= CW'(1);
            end
            HDR_EQ: state <= BODY;
            BODY:   if (data_i == SOH) state <= T1;
            T1, T0, TEQ: begin
              if (data_i == tag_byte) begin
                case (state)
                  T1:      begin state <= T0;  pend <= pend + data_i; end
                  T0:      begin state <= TEQ; pend <= pend + data_i; end
                  default: begin state <= D0;  pend <= '0; end
                endcase
              end else begin
                pend  <= '0;
                state <= (data_i == SOH) ? T1 : BODY;
              end
            end
            D0: begin val <= val_next; state <= D1;   end
            D1: begin val <= val_next; state <= D2;   end
            D2: begin val <= val_next; state <= TERM; end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
